div16x8_seq: RTL and testbench

DIV16X8_SEQ -- requirements
Module: div16x8_seq

---
 rtl/div16x8_seq_if.sv | 34 +++
 rtl/div16x8_seq.sv | 122 ++++++++++++
 tb/tb_div16x8_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div16x8_seq_if.sv
// Operand/result bundle for the 16/8 sequential divider.
// master drives the request side, slave is the divider.
interface div16x8_seq_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        done_flag;
    logic        busy;
    logic        div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  done_flag,
        input  busy,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output done_flag,
        output busy,
        output div_by_zero
    );
endinterface

// File: rtl/div16x8_seq.sv
// 16/8 unsigned restoring divider, one quotient bit per clock.
// Define DIV_SEG_EN to add a hex 7-segment view of remainder[3:0].
module div16x8_seq (
    input  logic clk,
    input  logic reset_a,
`ifdef DIV_SEG_EN
    output logic seg_a,
    output logic seg_b,
    output logic seg_c,
    output logic seg_d,
    output logic seg_e,
    output logic seg_f,
    output logic seg_g,
`endif
    div16x8_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] dvd_r;
    logic [7:0]  dvs_r;
    logic [7:0]  rem_r;
    logic [4:0]  cnt;

    logic [8:0]  part;
    logic        ge;
    logic [7:0]  diff;
    logic [7:0]  rem_nx;

    // dvd_r shifts out dividend bits and shifts in quotient bits
    assign part   = {rem_r, dvd_r[15]};
    assign ge     = part >= {1'b0, dvs_r};
    assign diff   = part[7:0] - dvs_r;
    assign rem_nx = ge ? diff : part[7:0];

`ifdef DIV_SEG_EN
    logic [6:0] seg;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
`endif

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state           <= IDLE;
            dvd_r           <= '0;
            dvs_r           <= '0;
            rem_r           <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.done_flag   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.div_by_zero <= 1'b0;
`ifdef DIV_SEG_EN
            seg             <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd_r    <= bus.dividend;
                        dvs_r    <= bus.divisor;
                        rem_r    <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    dvd_r <= {dvd_r[14:0], ge};
                    rem_r <= rem_nx;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        bus.quotient    <= {dvd_r[14:0], ge};
                        bus.remainder   <= rem_nx;
                        bus.div_by_zero <= (dvs_r == 8'd0);
                        bus.done_flag   <= 1'b1;
                        state           <= DONE;
`ifdef DIV_SEG_EN
                        seg             <= glyph(rem_nx[3:0]);
`endif
                    end
                end
                DONE: begin
                    bus.done_flag <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div16x8_seq.sv
// Scoreboard bench for div16x8_seq: results, latency, handshake, reset.
// Compile with DIV_SEG_EN to also check the 7-segment outputs.
module tb_div16x8_seq;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    div16x8_seq_if bus ();

`ifdef DIV_SEG_EN
    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [6:0] seg_out;
    assign seg_out = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
`endif

    div16x8_seq dut (
        .clk     (clk),
        .reset_a (reset_a),
`ifdef DIV_SEG_EN
        .seg_a   (seg_a),
        .seg_b   (seg_b),
        .seg_c   (seg_c),
        .seg_d   (seg_d),
        .seg_e   (seg_e),
        .seg_f   (seg_f),
        .seg_g   (seg_g),
`endif
        .bus     (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic [6:0]  seg;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // a..g, active high
    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(int dvd, int dvs, int c);
        exp_t e;
        if (dvs == 0) begin
            e.q  = 16'hFFFF;
            e.r  = dvd[7:0];
            e.dz = 1'b1;
        end else begin
            e.q  = 16'(dvd / dvs);
            e.r  = 8'(dvd % dvs);
            e.dz = 1'b0;
        end
        e.seg = glyph_tab[e.r[3:0]];
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_a && bus.done_flag) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("div_by_zero", bus.div_by_zero, e.dz);
                check("latency", cyc, e.cyc);
`ifdef DIV_SEG_EN
                check("seg", seg_out, e.seg);
`endif
            end
        end
    end

    // Call right after a negedge; start is sampled on the next posedge.
    task automatic run_div(int dvd, int dvs);
        int n;
        bus.start    = 1'b1;
        bus.dividend = 16'(dvd);
        bus.divisor  = 8'(dvs);
        sb.push_back(model(dvd, dvs, cyc + 17));
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done_flag && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done_flag) begin
            check("done_timeout", 0, 1);
        end else begin
            check("busy_in_done", bus.busy, 1);
            @(negedge clk);
            check("done_one_cycle", bus.done_flag, 0);
            check("busy_idle", bus.busy, 0);
        end
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int c0;
        int ndone;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(negedge clk);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done_flag, 0);
        check("rst_dz", bus.div_by_zero, 0);
`ifdef DIV_SEG_EN
        check("rst_seg", seg_out, 0);
`endif
        reset_a = 1'b1;
        @(negedge clk);

        run_div(1000, 7);
        run_div(935, 85);
        run_div(65535, 255);
        run_div(16'h04D2, 0);
        run_div(5, 9);
`ifdef DIV_SEG_EN
        check("seg_five", seg_out, 7'b1011011);
`endif
        check("hold_quotient", bus.quotient, 0);
        check("hold_remainder", bus.remainder, 5);

        // new operands pulsed at RUN step 5 must be ignored
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        sb.push_back(model(1000, 7, cyc + 17));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_sb_empty();
        repeat (2) @(negedge clk);

        // start held high: back-to-back divisions 18 edges apart
        c0 = cyc;
        bus.start    = 1'b1;
        bus.dividend = 16'd300;
        bus.divisor  = 8'd7;
        sb.push_back(model(300, 7, c0 + 17));
        sb.push_back(model(300, 7, c0 + 35));
        while (cyc < c0 + 19) @(negedge clk);
        bus.start = 1'b0;
        wait_sb_empty();
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_div(int'($urandom_range(0, 65535)), int'($urandom_range(1, 255)));
        end
        run_div(16'h04D2, 0);

        // reset at RUN step 8 aborts without a done pulse
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset_a = 1'b0;
        #1;
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dz", bus.div_by_zero, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done_flag, 0);
`ifdef DIV_SEG_EN
        check("abort_seg", seg_out, 0);
`endif
        @(negedge clk);
        reset_a = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done_flag) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle", bus.busy, 0);

        // start accepted on the first edge after reset release
        reset_a = 1'b0;
        @(negedge clk);
        reset_a = 1'b1;
        run_div(1000, 7);

        wait_sb_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
